// File: rtl/cpu_pkg.sv
// Shared widths and reset defaults for the instruction fetch front end.
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int INST_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: strict FIFO of {pc, inst} pairs with flush and occupancy count.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_pc,
  input  logic [INST_W-1:0]             push_inst,
  input  logic                          pop,
  input  logic                          flush,
  output logic                          valid,
  output logic [ADDR_W-1:0]             head_pc,
  output logic [INST_W-1:0]             head_inst,
  output logic [$clog2(DEPTH+1)-1:0]    count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_pop;

  assign valid     = (count != '0);
  assign do_pop    = pop & valid;
  assign head_pc   = mem_pc[rd_ptr];
  assign head_inst = mem_inst[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= push_pc;
        mem_inst[wr_ptr] <= push_inst;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pc register, issue throttling against buffer space, and
// one-deep in-flight tracking for a memory with fixed one-cycle read latency.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic              clk,
  input  logic              reset,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              issue;
  logic              pop;
  logic              push;
  logic              fifo_valid;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occupancy;

  assign pop  = inst_valid & inst_ready;
  // A response landing in a redirect cycle belongs to the old stream.
  assign push = inflight & ~redirect;

  // Counting the in-flight fetch as occupied space keeps the buffer from overflowing.
  always_comb begin
    occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    issue     = reset & ~halt & ~redirect & (occupancy < OCC_W'(DEPTH));
  end

  assign imem_rd    = issue;
  assign imem_addr  = pc;
  assign inst_valid = fifo_valid & reset;
  assign inst       = reset ? head_inst : '0;
  assign inst_pc    = reset ? head_pc   : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= issue;
      inflight_pc <= pc;
      if (redirect) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_pc   (inflight_pc),
    .push_inst (imem_data),
    .pop       (pop),
    .flush     (redirect),
    .valid     (fifo_valid),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory returning addr + 8'h10.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_rd;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       halt;
  logic       inst_valid;
  logic       inst_ready;
  logic [7:0] inst;
  logic [7:0] inst_pc;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= imem_rd ? imem_addr + 8'h10 : 8'hEE;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: the first cycle with reset=1.
  task automatic restart(input logic rdy);
    reset      = 1'b0;
    halt       = 1'b0;
    redirect   = 1'b0;
    inst_ready = rdy;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h5A;
    inst_ready  = 1'b1;
    repeat (3) begin
      next_cycle();
      vectors++;
      if ({imem_rd, inst_valid, inst, inst_pc} !== 18'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: got rd=%b v=%b inst=%h pc=%h expected all zero",
                 imem_rd, inst_valid, inst, inst_pc);
      end
    end
  endtask

  task automatic test_startup();
    reset      = 1'b1;
    inst_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++;
      if ({imem_rd, imem_addr} !== {1'b1, 8'(c)}) begin
        miscompares++;
        $display("FAIL startup_issue c=%0d: got rd=%b addr=%h expected rd=1 addr=%h",
                 c, imem_rd, imem_addr, 8'(c));
      end
      vectors++;
      if (c < 2) begin
        if (inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL startup_latency c=%0d: got valid=%b expected 0", c, inst_valid);
        end
      end else if ({inst_valid, inst_pc, inst} !== {1'b1, 8'(c - 2), 8'(c + 14)}) begin
        miscompares++;
        $display("FAIL startup_stream c=%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 c, inst_valid, inst_pc, inst, 8'(c - 2), 8'(c + 14));
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    restart(1'b0);
    for (int c = 0; c < 12; c++) begin
      #1;
      vectors++;
      if (imem_rd !== (c < DEPTH) || (c < DEPTH && imem_addr !== 8'(c))) begin
        miscompares++;
        $display("FAIL bp_issue c=%0d: got rd=%b addr=%h expected rd=%b addr=%h",
                 c, imem_rd, imem_addr, (c < DEPTH), 8'(c));
      end
      if (c >= 2) begin
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 8'h00, 8'h10}) begin
          miscompares++;
          $display("FAIL bp_hold c=%0d: got v=%b pc=%h inst=%h expected v=1 pc=00 inst=10",
                   c, inst_valid, inst_pc, inst);
        end
      end
      next_cycle();
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      vectors++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 8'(k), 8'(k + 16)}) begin
        miscompares++;
        $display("FAIL bp_drain k=%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 k, inst_valid, inst_pc, inst, 8'(k), 8'(k + 16));
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    restart(1'b0);
    repeat (4) next_cycle();
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    #1;
    vectors++;
    if (imem_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_no_issue: got rd=%b expected 0", imem_rd);
    end
    next_cycle();
    redirect = 1'b0;
    for (int c = 1; c < 3; c++) begin
      #1;
      vectors++;
      if ({imem_rd, imem_addr, inst_valid} !== {1'b1, 8'(8'h3F + c), 1'b0}) begin
        miscompares++;
        $display("FAIL redir_refetch c=%0d: got rd=%b addr=%h v=%b expected rd=1 addr=%h v=0",
                 c, imem_rd, imem_addr, inst_valid, 8'(8'h3F + c));
      end
      next_cycle();
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 8'(8'h40 + k), 8'(8'h50 + k)}) begin
        miscompares++;
        $display("FAIL redir_stream k=%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 k, inst_valid, inst_pc, inst, 8'(8'h40 + k), 8'(8'h50 + k));
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_pop();
    restart(1'b1);
    repeat (5) next_cycle();
    redirect    = 1'b1;
    redirect_pc = 8'h80;
    #1;
    vectors++;
    if ({imem_rd, inst_valid, inst_pc} !== {1'b0, 1'b1, 8'h03}) begin
      miscompares++;
      $display("FAIL redir_pop_head: got rd=%b v=%b pc=%h expected rd=0 v=1 pc=03",
               imem_rd, inst_valid, inst_pc);
    end
    next_cycle();
    redirect = 1'b0;
    for (int c = 1; c < 3; c++) begin
      #1;
      vectors++;
      if (inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL redir_pop_flush c=%0d: got v=%b pc=%h expected v=0", c, inst_valid, inst_pc);
      end
      next_cycle();
    end
    #1;
    vectors++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 8'h80, 8'h90}) begin
      miscompares++;
      $display("FAIL redir_pop_first: got v=%b pc=%h inst=%h expected v=1 pc=80 inst=90",
               inst_valid, inst_pc, inst);
    end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [7:0] seq [4];
    seq[0] = 8'hFE;
    seq[1] = 8'hFF;
    seq[2] = 8'h00;
    seq[3] = 8'h01;
    restart(1'b1);
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    next_cycle();
    redirect = 1'b0;
    for (int c = 1; c < 7; c++) begin
      #1;
      if (c < 4) begin
        vectors++;
        if ({imem_rd, imem_addr} !== {1'b1, seq[c - 1]}) begin
          miscompares++;
          $display("FAIL wrap_issue c=%0d: got rd=%b addr=%h expected rd=1 addr=%h",
                   c, imem_rd, imem_addr, seq[c - 1]);
        end
      end
      if (c >= 3) begin
        vectors++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, seq[c - 3], seq[c - 3] + 8'h10}) begin
          miscompares++;
          $display("FAIL wrap_stream c=%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                   c, inst_valid, inst_pc, inst, seq[c - 3], seq[c - 3] + 8'h10);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_halt();
    restart(1'b1);
    repeat (4) next_cycle();
    halt = 1'b1;
    for (int c = 4; c < 10; c++) begin
      redirect    = (c == 7);
      redirect_pc = 8'h20;
      #1;
      vectors++;
      if (imem_rd !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_no_issue c=%0d: got rd=%b expected 0", c, imem_rd);
      end
      if (c < 7) begin
        vectors++;
        if (c < 6 && {inst_valid, inst_pc} !== {1'b1, 8'(c - 2)}) begin
          miscompares++;
          $display("FAIL halt_drain c=%0d: got v=%b pc=%h expected v=1 pc=%h",
                   c, inst_valid, inst_pc, 8'(c - 2));
        end else if (c == 6 && inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL halt_empty: got v=%b pc=%h expected v=0", inst_valid, inst_pc);
        end
      end
      next_cycle();
    end
    redirect = 1'b0;
    halt     = 1'b0;
    #1;
    vectors++;
    if ({imem_rd, imem_addr} !== {1'b1, 8'h20}) begin
      miscompares++;
      $display("FAIL halt_resume: got rd=%b addr=%h expected rd=1 addr=20", imem_rd, imem_addr);
    end
    next_cycle();
    next_cycle();
    vectors++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 8'h20, 8'h30}) begin
      miscompares++;
      $display("FAIL halt_first: got v=%b pc=%h inst=%h expected v=1 pc=20 inst=30",
               inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_reset_mid();
    restart(1'b0);
    repeat (3) next_cycle();
    reset = 1'b0;
    #1;
    vectors++;
    if ({imem_rd, inst_valid, inst, inst_pc} !== 18'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got rd=%b v=%b inst=%h pc=%h expected all zero",
               imem_rd, inst_valid, inst, inst_pc);
    end
    next_cycle();
    reset      = 1'b1;
    inst_ready = 1'b1;
    #1;
    vectors++;
    if ({imem_rd, imem_addr, inst_valid, inst, inst_pc} !== {1'b1, 8'h00, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL midreset_restart: got rd=%b addr=%h v=%b inst=%h pc=%h expected rd=1 addr=00 v=0 inst=00 pc=00",
               imem_rd, imem_addr, inst_valid, inst, inst_pc);
    end
    next_cycle();
    #1;
    vectors++;
    if ({imem_rd, imem_addr, inst_valid} !== {1'b1, 8'h01, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_gap: got rd=%b addr=%h v=%b expected rd=1 addr=01 v=0",
               imem_rd, imem_addr, inst_valid);
    end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 8'(k), 8'(k + 16)}) begin
        miscompares++;
        $display("FAIL midreset_stream k=%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 k, inst_valid, inst_pc, inst, 8'(k), 8'(k + 16));
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
